// File: rtl/mznm_pkg.sv
// Shared ISA constants for the fetch/decode path: opcode field, the
// immediate-carrying opcodes, the NOP word and the F/D state encoding.
package mznm_pkg;

    localparam int OPC_W = 5;

    localparam logic [OPC_W-1:0] OPC_NOP  = 5'd0;
    localparam logic [OPC_W-1:0] OPC_LDM  = 5'd20;
    localparam logic [OPC_W-1:0] OPC_IADD = 5'd21;
    localparam logic [OPC_W-1:0] OPC_LDD  = 5'd22;
    localparam logic [OPC_W-1:0] OPC_STD  = 5'd23;

    localparam logic [15:0] NOP_WORD = 16'h0000;

    localparam logic [0:0] S_OP  = 1'b0;
    localparam logic [0:0] S_IMM = 1'b1;

    function automatic logic opc_has_imm(input logic [OPC_W-1:0] opc);
        return (opc == OPC_LDM) || (opc == OPC_IADD) ||
               (opc == OPC_LDD) || (opc == OPC_STD);
    endfunction

endpackage

// File: rtl/fd_buffer_if.sv
// Fetch-side inputs and decode-side packet outputs of the F/D buffer.
interface fd_buffer_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
);
    logic             fetchValid;
    logic [15:0]      fetchWord;
    logic [PC_W-1:0]  fetchPc;
    logic             stall;
    logic             flush;
    logic [15:0]      instrOut;
    logic [15:0]      immOut;
    logic [PC_W-1:0]  pcOut;
    logic             validOut;
    logic             hasImmOut;
    logic             immPending;
    logic [CNT_W-1:0] issuedCount;

    modport master (
        output fetchValid, fetchWord, fetchPc, stall, flush,
        input  instrOut, immOut, pcOut, validOut, hasImmOut, immPending, issuedCount
    );

    modport slave (
        input  fetchValid, fetchWord, fetchPc, stall, flush,
        output instrOut, immOut, pcOut, validOut, hasImmOut, immPending, issuedCount
    );
endinterface

// File: rtl/imm_opcode_decode.sv
// Flags opcodes that are followed by a 16-bit immediate word; also used by
// the decode-stage control unit.
module imm_opcode_decode
    import mznm_pkg::*;
(
    input  logic [OPC_W-1:0] i_opcode,
    output logic             o_is_imm
);
    assign o_is_imm = opc_has_imm(i_opcode);
endmodule

// File: rtl/fd_buffer.sv
// Fetch/Decode stage buffer: registers on the falling edge and pairs an
// immediate-carrying opcode word with the word that follows it.
//
// state | meaning
// S_OP  | expecting an opcode word
// S_IMM | opcode word held, waiting for its immediate word
module fd_buffer
    import mznm_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input logic       Clk,
    input logic       Rst,
    fd_buffer_if.slave bus
);
    logic [0:0]       r_state;
    logic [15:0]      r_hold_word;
    logic [PC_W-1:0]  r_hold_pc;
    logic [15:0]      r_instr;
    logic [15:0]      r_imm;
    logic [PC_W-1:0]  r_pc;
    logic             r_valid;
    logic             r_has_imm;
    logic [CNT_W-1:0] r_count;

    logic             w_is_imm;
    logic             w_cnt_max;

    imm_opcode_decode u_imm_dec (
        .i_opcode (bus.fetchWord[15:11]),
        .o_is_imm (w_is_imm)
    );

    assign w_cnt_max = &r_count;

    always_ff @(negedge Clk) begin
        if (Rst) begin
            r_state     <= S_OP;
            r_hold_word <= NOP_WORD;
            r_hold_pc   <= '0;
            r_instr     <= NOP_WORD;
            r_imm       <= '0;
            r_pc        <= '0;
            r_valid     <= 1'b0;
            r_has_imm   <= 1'b0;
            r_count     <= '0;
        end else if (bus.flush) begin
            // pcOut is left alone so the last issued address stays visible
            r_state   <= S_OP;
            r_instr   <= NOP_WORD;
            r_imm     <= '0;
            r_valid   <= 1'b0;
            r_has_imm <= 1'b0;
        end else if (!bus.stall) begin
            r_instr   <= NOP_WORD;
            r_imm     <= '0;
            r_valid   <= 1'b0;
            r_has_imm <= 1'b0;
            case (r_state)
                S_OP: begin
                    if (bus.fetchValid && w_is_imm) begin
                        r_hold_word <= bus.fetchWord;
                        r_hold_pc   <= bus.fetchPc;
                        r_state     <= S_IMM;
                    end else if (bus.fetchValid) begin
                        r_instr <= bus.fetchWord;
                        r_pc    <= bus.fetchPc;
                        r_valid <= 1'b1;
                        if (!w_cnt_max) r_count <= r_count + CNT_W'(1);
                    end
                end
                S_IMM: begin
                    // the word here is raw immediate data, never opcode-decoded
                    if (bus.fetchValid) begin
                        r_instr   <= r_hold_word;
                        r_pc      <= r_hold_pc;
                        r_imm     <= bus.fetchWord;
                        r_has_imm <= 1'b1;
                        r_valid   <= 1'b1;
                        r_state   <= S_OP;
                        if (!w_cnt_max) r_count <= r_count + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign bus.instrOut    = r_instr;
    assign bus.immOut      = r_imm;
    assign bus.pcOut       = r_pc;
    assign bus.validOut    = r_valid;
    assign bus.hasImmOut   = r_has_imm;
    assign bus.immPending  = (r_state == S_IMM);
    assign bus.issuedCount = r_count;

endmodule

// File: tb/tb_fd_buffer.sv
// Self-checking bench for fd_buffer: directed vectors, a queue-based packet
// model compared every cycle, and literal checks along the way.
module tb_fd_buffer;
    logic        clk;
    logic        rst;
    logic        fv;
    logic [15:0] fw;
    logic [31:0] fp;
    logic        st;
    logic        fl;

    int n_cmp = 0;
    int n_bad = 0;

    fd_buffer_if #(.PC_W(32), .CNT_W(16)) bus ();
    fd_buffer_if #(.PC_W(32), .CNT_W(2))  bus_s ();

    assign bus.fetchValid   = fv;
    assign bus.fetchWord    = fw;
    assign bus.fetchPc      = fp;
    assign bus.stall        = st;
    assign bus.flush        = fl;
    assign bus_s.fetchValid = fv;
    assign bus_s.fetchWord  = fw;
    assign bus_s.fetchPc    = fp;
    assign bus_s.stall      = st;
    assign bus_s.flush      = fl;

    fd_buffer #(.PC_W(32), .CNT_W(16)) dut   (.Clk(clk), .Rst(rst), .bus(bus));
    fd_buffer #(.PC_W(32), .CNT_W(2))  dut_s (.Clk(clk), .Rst(rst), .bus(bus_s));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    logic [47:0] hold_q[$];
    logic [15:0] e_instr, e_imm;
    logic [31:0] e_pc;
    logic        e_valid, e_has;
    int          e_cnt;
    bit          m_live = 0;

    function automatic bit model_is_imm(input logic [15:0] w);
        int opc;
        opc = int'(w[15:11]);
        return (opc == 20) || (opc == 21) || (opc == 22) || (opc == 23);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            hold_q.delete();
            e_instr = 0; e_imm = 0; e_pc = 0; e_valid = 0; e_has = 0; e_cnt = 0;
            m_live = 1;
        end else if (fl) begin
            hold_q.delete();
            e_instr = 0; e_imm = 0; e_valid = 0; e_has = 0;
        end else if (!st) begin
            e_instr = 0; e_imm = 0; e_valid = 0; e_has = 0;
            if (fv && hold_q.size() != 0) begin
                e_instr = hold_q[0][47:32];
                e_pc    = hold_q[0][31:0];
                e_imm   = fw;
                e_has   = 1;
                e_valid = 1;
                void'(hold_q.pop_front());
                e_cnt++;
            end else if (fv && model_is_imm(fw)) begin
                hold_q.push_back({fw, fp});
            end else if (fv) begin
                e_instr = fw;
                e_pc    = fp;
                e_valid = 1;
                e_cnt++;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (m_live) begin
            chk("instrOut",    32'(bus.instrOut),   32'(e_instr));
            chk("immOut",      32'(bus.immOut),     32'(e_imm));
            chk("pcOut",       bus.pcOut,           e_pc);
            chk("validOut",    32'(bus.validOut),   32'(e_valid));
            chk("hasImmOut",   32'(bus.hasImmOut),  32'(e_has));
            chk("immPending",  32'(bus.immPending), 32'(hold_q.size() != 0));
            chk("issuedCount", 32'(bus.issuedCount), (e_cnt > 65535) ? 32'd65535 : 32'(e_cnt));
            chk("issuedCount_sat2", 32'(bus_s.issuedCount), (e_cnt > 3) ? 32'd3 : 32'(e_cnt));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic r, input logic f, input logic s, input logic v,
                        input logic [15:0] w, input logic [31:0] p);
        @(posedge clk);
        rst = r; fl = f; st = s; fv = v; fw = w; fp = p;
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1; fl = 0; st = 0; fv = 0; fw = 0; fp = 0;

        // 1: reset then two single-word instructions
        step(1, 0, 0, 0, 16'h0000, 0);
        step(1, 0, 0, 0, 16'h0000, 0);
        chk("t1_reset_valid", 32'(bus.validOut), 0);
        chk("t1_reset_instr", 32'(bus.instrOut), 0);
        chk("t1_reset_cnt",   32'(bus.issuedCount), 0);
        step(0, 0, 0, 1, 16'h0800, 0);
        chk("t1_instr0", 32'(bus.instrOut), 32'h0800);
        chk("t1_valid0", 32'(bus.validOut), 1);
        step(0, 0, 0, 1, 16'h1000, 1);
        chk("t1_instr1", 32'(bus.instrOut), 32'h1000);
        chk("t1_pc1",    bus.pcOut, 1);
        chk("t1_cnt",    32'(bus.issuedCount), 2);

        // 2: LDM + immediate (0xBEEF top bits look like STD, must not be decoded)
        step(0, 0, 0, 1, 16'hA123, 4);
        chk("t2_bubble", 32'(bus.validOut), 0);
        chk("t2_pend",   32'(bus.immPending), 1);
        step(0, 0, 0, 1, 16'hBEEF, 5);
        chk("t2_instr", 32'(bus.instrOut), 32'hA123);
        chk("t2_imm",   32'(bus.immOut), 32'hBEEF);
        chk("t2_pc",    bus.pcOut, 4);
        chk("t2_has",   32'(bus.hasImmOut), 1);
        chk("t2_pend0", 32'(bus.immPending), 0);

        // 3: stall holds everything for three edges
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 1, 16'h0805, 6);
            chk("t3_hold_instr", 32'(bus.instrOut), 32'hA123);
            chk("t3_hold_cnt",   32'(bus.issuedCount), 3);
        end
        step(0, 0, 0, 1, 16'h0805, 6);
        chk("t3_issue", 32'(bus.instrOut), 32'h0805);
        chk("t3_cnt",   32'(bus.issuedCount), 4);
        step(0, 0, 0, 0, 16'h0000, 0);
        chk("t3_once", 32'(bus.validOut), 0);

        // 4: flush drops a half-assembled instruction
        step(0, 0, 0, 1, 16'hA001, 8);
        step(0, 1, 0, 1, 16'h1234, 9);
        chk("t4_valid", 32'(bus.validOut), 0);
        chk("t4_pend",  32'(bus.immPending), 0);
        chk("t4_pc",    bus.pcOut, 6);
        step(0, 0, 0, 1, 16'h0800, 10);
        chk("t4_instr", 32'(bus.instrOut), 32'h0800);
        chk("t4_has",   32'(bus.hasImmOut), 0);

        // 5: gaps between opcode and immediate
        step(0, 0, 0, 1, 16'hA800, 12);
        step(0, 0, 0, 0, 16'h0000, 13);
        step(0, 0, 0, 0, 16'h0000, 14);
        chk("t5_pend", 32'(bus.immPending), 1);
        step(0, 0, 0, 1, 16'h0042, 15);
        chk("t5_instr", 32'(bus.instrOut), 32'hA800);
        chk("t5_imm",   32'(bus.immOut), 32'h0042);
        chk("t5_pc",    bus.pcOut, 12);
        chk("t5_cnt",   32'(bus.issuedCount), 6);

        // 6: saturation on the narrow counter, flush beats stall
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 16'h1000 + 16'(i), 32'(20 + i));
        chk("t6_cnt",     32'(bus.issuedCount), 9);
        chk("t6_sat",     32'(bus_s.issuedCount), 3);
        step(0, 1, 1, 1, 16'h0800, 30);
        chk("t6_flush_valid", 32'(bus.validOut), 0);
        chk("t6_flush_cnt",   32'(bus.issuedCount), 9);

        // reset mid-instruction clears pc and count
        step(0, 0, 0, 1, 16'hB000, 40);
        step(1, 0, 0, 1, 16'h5555, 41);
        chk("t7_pend", 32'(bus.immPending), 0);
        chk("t7_pc",   bus.pcOut, 0);
        chk("t7_cnt",  32'(bus.issuedCount), 0);
        step(0, 0, 0, 1, 16'h0801, 42);
        chk("t7_instr", 32'(bus.instrOut), 32'h0801);
        step(0, 0, 0, 0, 16'h0000, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fd_buffer.md
Name: fd_buffer

Overview:
- Fetch/Decode pipeline register feeding the decode stage, which in turn drives the D/E buffer.
- Accepts 16-bit instruction words from fetch.
- Assembles two-word instructions (opcode word plus 16-bit immediate word) into a single decode packet.
- Handles stall (hold), flush (bubble) and reset.

Parameters:
- OPC_W, 5, opcode field width; the opcode is fetchWord[15:11].
- PC_W, 32, program counter width.
- CNT_W, 16, width of the saturating issued-instruction counter.

Ports:
- Clk  in  1  pipeline clock; the block registers on the falling edge, like all stage buffers.
- Rst  in  1  synchronous, active-high reset, sampled on the falling edge of Clk.
- fetchValid  in  1  fetchWord/fetchPc carry a real word this cycle.
- fetchWord  in  16  instruction or immediate word from instruction memory.
- fetchPc  in  PC_W  address of fetchWord.
- stall  in  1  hazard-unit hold request.
- flush  in  1  taken branch/call/ret resolved downstream; discard everything in this stage.
- instrOut  out  16  opcode word to decode.
- immOut  out  16  immediate word; 0 when hasImmOut=0.
- pcOut  out  PC_W  address of the opcode word.
- validOut  out  1  the packet is a real instruction; 0 means bubble.
- hasImmOut  out  1  the packet carries an immediate.
- immPending  out  1  an opcode word is held waiting for its immediate (state S_IMM).
- issuedCount  out  CNT_W  count of valid packets issued, saturating at all-ones.

Behaviour:
- States:
  - S_OP: expecting an opcode word.
  - S_IMM: holding an opcode word, expecting its immediate word.
- Reset value of every output and holding register is 0: instrOut=NOP (16'h0000), immOut=0, pcOut=0, validOut=0, hasImmOut=0, immPending=0, issuedCount=0. State resets to S_OP.
- isImm is combinational: 1 when fetchWord[15:11] is one of the package constants OPC_LDM, OPC_IADD, OPC_LDD, OPC_STD.
- Priority at each falling edge: Rst > flush > stall > normal.
- flush:
  - instrOut=0, immOut=0, hasImmOut=0, validOut=0.
  - State goes to S_OP and any held opcode word is discarded.
  - pcOut keeps its value; issuedCount unchanged.
- stall (no flush): every output, the holding registers and the state hold. The fetch word is not consumed; fetch is required to re-present it.
- S_OP, fetchValid=0: bubble (validOut=0, instrOut=0, hasImmOut=0); stay in S_OP.
- S_OP, fetchValid=1, isImm=0:
  - instrOut=fetchWord, pcOut=fetchPc, immOut=0, hasImmOut=0, validOut=1.
  - issuedCount+1.
- S_OP, fetchValid=1, isImm=1:
  - Latch holdWord=fetchWord and holdPc=fetchPc; go to S_IMM.
  - Output a bubble: validOut=0, instrOut=0.
- S_IMM, fetchValid=0: bubble; stay in S_IMM with the held values kept.
- S_IMM, fetchValid=1:
  - instrOut=holdWord, pcOut=holdPc, immOut=fetchWord, hasImmOut=1, validOut=1; go to S_OP.
  - issuedCount+1.
  - fetchWord is not opcode-decoded in this state, even if its top bits match an immediate opcode.
- issuedCount saturates: at all-ones it stays all-ones.
- Latency:
  - single-word instruction: one edge from acceptance to validOut.
  - two-word instruction: validOut on the edge that accepts the immediate word.
- Flush in S_IMM drops the half-assembled instruction. The next accepted word is decoded as an opcode.
- Rst mid-instruction behaves the same as flush, and additionally clears pcOut and issuedCount.

Decomposition:
- Shared package mznm_pkg holds:
  - OPC_W and the opcode constants (OPC_NOP=5'd0, OPC_LDM, OPC_IADD, OPC_LDD, OPC_STD; values from the ISA sheet).
  - NOP_WORD=16'h0000.
  - The fd state encoding S_OP=1'b0, S_IMM=1'b1.
- One sub-module: imm_opcode_decode, a combinational isImm from fetchWord[15:11]. It is shared with the decode stage's control unit.
- The FSM, holding registers and counter stay in fd_buffer.

Test Plan:
1. Rst=1 for 2 edges, then sequential words 0x0800 (non-imm, pc 0), 0x1000 (pc 1) -> after reset all outputs 0; then instrOut 0x0800/pcOut 0 validOut=1, next edge 0x1000/pc 1; issuedCount=2.
2. LDM opcode word (pc 4) then 0xBEEF (pc 5) -> edge 1: validOut=0, immPending=1; edge 2: instrOut=LDM word, immOut=0xBEEF, pcOut=4, hasImmOut=1, validOut=1, immPending=0.
3. Non-imm word with stall=1 for 3 edges -> outputs and issuedCount frozen at prior values; on release the word is issued exactly once.
4. LDM word, then flush=1 together with a valid immediate word -> validOut=0, immPending=0; next word 0x0800 is issued as an opcode, not as an immediate.
5. Imm opcode, then 2 cycles fetchValid=0, then 0x0042 -> bubbles while immPending=1; then packet with immOut=0x0042 and the original pcOut.
6. Force issuedCount to 0xFFFE and issue 3 instructions -> counter reads 0xFFFF and stays there; flush and stall together -> flush wins, validOut=0.
